// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick function for the SDRAM Wishbone arbiter.
// The fixed-priority port 0 option is selected with SDRAM_ARB_PORT0_PRIO_EN.
package sdram_arb_pkg;

    localparam int MAX_PORTS = 8;
    localparam int MAX_LW    = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DRAIN
    } state_t;

    // First requester strictly after 'last', wrapping modulo n; one-hot result.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [MAX_LW-1:0]    last,
        input int unsigned          n
    );
        logic [MAX_PORTS-1:0] g;
        logic                 found;
        int unsigned          idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
            if (i <= n) begin
                idx = (32'(last) + i) % n;
                if (!found && req[idx[MAX_LW-1:0]]) begin
                    g[idx[MAX_LW-1:0]] = 1'b1;
                    found              = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Combinational round-robin picker: request vector and last grant index in,
// one-hot winner out (all zero when nobody requests).
module sdram_arb_rr_pick
    import sdram_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int LW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [LW-1:0]        last_i,
    output logic [NUM_PORTS-1:0] grant_o
);

    assign grant_o = NUM_PORTS'(rr_pick(MAX_PORTS'(req_i),
                                        MAX_LW'(last_i),
                                        NUM_PORTS));

endmodule

// File: rtl/sdram_wb_arbiter.sv
// N-port Wishbone classic arbiter in front of sdram_ctrl_wb with a timeout watchdog.
// Define SDRAM_ARB_PORT0_PRIO_EN to make port 0 win every arbitration it enters.
module sdram_wb_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int NUM_PORTS      = 4,
    parameter  int WB_ADDR_WIDTH  = 24,
    parameter  int WB_DATA_WIDTH  = 16,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int N              = NUM_PORTS,
    localparam int AW             = WB_ADDR_WIDTH,
    localparam int DW             = WB_DATA_WIDTH,
    localparam int SW             = WB_DATA_WIDTH / 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [N-1:0]    s_cyc_i,
    input  logic [N-1:0]    s_stb_i,
    input  logic [N-1:0]    s_we_i,
    input  logic [N*AW-1:0] s_adr_i,
    input  logic [N*DW-1:0] s_dat_i,
    input  logic [N*SW-1:0] s_sel_i,
    output logic [DW-1:0]   s_dat_o,
    output logic [N-1:0]    s_ack_o,
    output logic [N-1:0]    s_err_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    output logic [SW-1:0]   m_sel_o,
    input  logic [DW-1:0]   m_dat_i,
    input  logic            m_ack_i,
    output logic [N-1:0]    grant_o
);

    localparam int LW = $clog2(N);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t          state_q;
    logic [N-1:0]    req, req_rr, pick, win_d;
    logic [N-1:0]    gnt_q, ack_q, err_q;
    logic [LW-1:0]   win_idx_d, gnt_idx_q, last_q;
    logic            upd_last;
    logic            timeout;
    logic [CW-1:0]   cnt_q;
    logic            m_cyc_q, m_stb_q, m_we_q;
    logic [AW-1:0]   m_adr_q;
    logic [DW-1:0]   m_dat_q, s_dat_q;
    logic [SW-1:0]   m_sel_q;

    assign req = s_cyc_i & s_stb_i;

`ifdef SDRAM_ARB_PORT0_PRIO_EN
    // Port 0 bypasses the rotation so ports 1..N-1 keep their own fair order.
    assign req_rr   = req & ~{{(N-1){1'b0}}, 1'b1};
    assign win_d    = req[0] ? {{(N-1){1'b0}}, 1'b1} : pick;
    assign upd_last = ~req[0];
`else
    assign req_rr   = req;
    assign win_d    = pick;
    assign upd_last = 1'b1;
`endif

    sdram_arb_rr_pick #(
        .NUM_PORTS (N)
    ) u_pick (
        .req_i   (req_rr),
        .last_i  (last_q),
        .grant_o (pick)
    );

    always_comb begin
        win_idx_d = '0;
        for (int k = 0; k < N; k++) begin
            if (win_d[k]) win_idx_d = LW'(k);
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= LW'(N - 1);
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            m_cyc_q   <= 1'b0;
            m_stb_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_adr_q   <= '0;
            m_dat_q   <= '0;
            m_sel_q   <= '0;
            s_dat_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q     <= win_d;
                        gnt_idx_q <= win_idx_d;
                        if (upd_last) last_q <= win_idx_d;
                        m_we_q    <= s_we_i[win_idx_d];
                        m_adr_q   <= s_adr_i[win_idx_d*AW +: AW];
                        m_dat_q   <= s_dat_i[win_idx_d*DW +: DW];
                        m_sel_q   <= s_sel_i[win_idx_d*SW +: SW];
                        m_cyc_q   <= 1'b1;
                        m_stb_q   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (m_ack_i) begin
                        if (!m_we_q) s_dat_q <= m_dat_i;
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        ack_q   <= gnt_q;
                        state_q <= RESP;
                    end else if (timeout) begin
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        err_q   <= gnt_q;
                        state_q <= RESP;
                    end else if (!s_cyc_i[gnt_idx_q]) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (m_ack_i || timeout) begin
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                RESP: begin
                    gnt_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_dat_o = s_dat_q;
    assign s_ack_o = ack_q;
    assign s_err_o = err_q;
    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_stb_q;
    assign m_we_o  = m_we_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;
    assign m_sel_o = m_sel_q;
    assign grant_o = gnt_q;

endmodule
